// File: rtl/fifo_byte_serializer_if.sv
// Byte serializer bus bundle: the FIFO read port plus the valid/ready byte stream.
// master = serializer side, slave = FIFO/downstream side.
interface fifo_byte_serializer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BYTE_W = 8
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [BYTE_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_data, m_valid
  );
endinterface

// File: rtl/fifo_byte_serializer.sv
// Drains DATA_W words from a registered-read FIFO and emits them as a BYTE_W valid/ready stream.
// Optional macro SER_MSB_FIRST_EN: send the most significant byte of each word first.
module fifo_byte_serializer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_byte_serializer_if.master bus_io,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      word_cnt_o
);

  localparam int unsigned NB   = DATA_W / BYTE_W;
  localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StSend} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!bus_io.fifo_empty) state_d = StRd;
      end
      StRd: begin
        state_d = StCap;
      end
      StCap: begin
        shift_d = bus_io.fifo_rd_data;
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (bus_io.m_ready) begin
          // The outgoing byte always sits at the same end, so shift it away on acceptance.
`ifdef SER_MSB_FIRST_EN
          shift_d = shift_q << BYTE_W;
`else
          shift_d = shift_q >> BYTE_W;
`endif
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            cnt_d   = cnt_q + 1'b1;
            state_d = bus_io.fifo_empty ? StIdle : StRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.fifo_rd_en = (state_q == StRd);
  assign bus_io.m_valid    = (state_q == StSend);
`ifdef SER_MSB_FIRST_EN
  assign bus_io.m_data     = shift_q[DATA_W-1 -: BYTE_W];
`else
  assign bus_io.m_data     = shift_q[BYTE_W-1:0];
`endif
  assign busy_o            = (state_q != StIdle);
  assign word_cnt_o        = cnt_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer with a small registered-read FIFO model.
module tb_fifo_byte_serializer;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] word_cnt;

  fifo_byte_serializer_if #(.DATA_W(32), .BYTE_W(8)) bus ();

  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_io     (bus),
    .busy_o     (busy),
    .word_cnt_o (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read.
  logic [31:0] mem [0:31];
  int          wr_ptr;
  int          rd_ptr;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= mem[rd_ptr];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  // Output monitor.
  logic [7:0] cap   [0:63];
  int         stamp [0:63];
  int         ncap, nrd, cyc, nstall, stall_viol;
  logic       prev_stall;
  logic [7:0] prev_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus.fifo_rd_en) nrd <= nrd + 1;
      if (bus.m_valid && bus.m_ready) begin
        cap[ncap]   <= bus.m_data;
        stamp[ncap] <= cyc;
        ncap        <= ncap + 1;
      end
      if (bus.m_valid && !bus.m_ready) nstall <= nstall + 1;
      if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data))
        stall_viol <= stall_viol + 1;
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_data  <= bus.m_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  int nerr;
  int nchk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
`ifdef SER_MSB_FIRST_EN
    exp_byte = w[31-8*k -: 8];
`else
    exp_byte = w[8*k +: 8];
`endif
  endfunction

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_caps(input int target);
    int n = 0;
    while (ncap < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cap_timeout", ncap, target);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (bus.m_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_timeout", {31'd0, bus.m_valid}, 32'd1);
  endtask

  task automatic chk_word(input string tag, input int base, input logic [31:0] w);
    for (int k = 0; k < 4; k++) chk(tag, cap[base+k], exp_byte(w, k));
  endtask

  logic [6:0] bp_pat;
  int         push_cyc;
  int         busy_cnt;

  initial begin
    nerr = 0; nchk = 0;
    wr_ptr = 0; rd_ptr = 0;
    ncap = 0; nrd = 0; cyc = 0; nstall = 0; stall_viol = 0;
    prev_stall = 1'b0; prev_data = '0;
    bus.fifo_rd_data = '0;
    bus.m_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_data", {24'd0, bus.m_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single word, ready held high.
    push_cyc = cyc;
    push(32'hA1B2C3D4);
    wait_caps(4);
    @(posedge clk); #1;
    chk_word("single_byte", 0, 32'hA1B2C3D4);
    chk("single_latency", stamp[0] - push_cyc, 3);
    chk("single_contig", stamp[3] - stamp[0], 3);
    chk("single_rd_pulses", nrd, 1);
    chk("single_cnt", {16'd0, word_cnt}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("single_rd_quiet", nrd, 1);

    // Backpressure: ready pattern 1,0,0,1,0,1,1 once valid is up.
    bus.m_ready = 1'b0;
    push(32'hA1B2C3D4);
    wait_valid();
    bp_pat = 7'b1101001;  // bit 0 first
    for (int i = 0; i < 7; i++) begin
      bus.m_ready = bp_pat[i];
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    wait_caps(8);
    chk_word("bp_byte", 4, 32'hA1B2C3D4);
    chk("bp_stalls", nstall, 3);
    chk("bp_stable", stall_viol, 0);
    chk("bp_cnt", {16'd0, word_cnt}, 32'd2);

    // Back-to-back words: two bubble cycles between them.
    push(32'h03020100);
    push(32'h07060504);
    wait_caps(16);
    @(posedge clk); #1;
    chk_word("b2b_w0", 8, 32'h03020100);
    chk_word("b2b_w1", 12, 32'h07060504);
    chk("b2b_w0_contig", stamp[11] - stamp[8], 3);
    chk("b2b_gap", stamp[12] - stamp[11], 3);
    chk("b2b_cnt", {16'd0, word_cnt}, 32'd4);
    chk("b2b_rd_pulses", nrd, 4);

    // Empty gap between two words.
    push(32'h11223344);
    wait_caps(20);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    chk("gap_busy", busy_cnt, 0);
    push_cyc = cyc;
    push(32'h55667788);
    wait_caps(24);
    chk_word("gap_w0", 16, 32'h11223344);
    chk_word("gap_w1", 20, 32'h55667788);
    chk("gap_latency", stamp[20] - push_cyc, 3);
    chk("gap_cnt", {16'd0, word_cnt}, 32'd6);

    // Asynchronous reset in the middle of SEND.
    bus.m_ready = 1'b0;
    push(32'hDEADBEEF);
    wait_valid();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("arst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_cnt", {16'd0, word_cnt}, 32'd0);
    #2;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_idle_busy", {31'd0, busy}, 32'd0);
    chk("arst_idle_valid", {31'd0, bus.m_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
